winograd_tile_engine: RTL
=========================

// Module: winograd_tile_engine
// PURPOSE
//  Responder side of the tile start/done handshake used by the 10x12 Winograd convolution controller.
//  Computes one F(4x4,3x3) Winograd tile, Y = A^T[(G g G^T) .* (B^T d B)]A, on a 6x6 input tile and a 3x3 kernel.
//  Uses integer-scaled G (24*G), so every output is 576x the true correlation; the downstream divide-by-576 stage removes the scale.
//  Multi-cycle, row-serial datapath; one tile in flight at a time.
// PARAMETERS
//  DATA_W  32  two's-complement element width of all array ports; fixed at 32 in this design
// PORTS
//  clk         in   1                 clock, rising edge
//  rst_n       in   1                 asynchronous active-low reset
//  start       in   1                 request; sampled only in ST_IDLE/ST_DONE
//  kernel_in   in   DATA_W [0:2][0:2] kernel g; captured on the accepting edge
//  tile_in     in   DATA_W [0:5][0:5] input tile d; captured on the accepting edge
//  result_out  out  DATA_W [0:3][0:3] 576*Y, registered
//  done        out  1                 level; high from completion until the next start is accepted
//  ovf         out  1                 sticky product-overflow flag (present only with WINOGRAD_TILE_OVF_EN)
// BEHAVIOUR
//  Reset: done=0, result_out=0, ovf=0, all scratch=0, state=ST_IDLE. Reset mid-tile aborts the tile with no output.
//  Accept: start=1 in ST_IDLE or ST_DONE captures kernel_in/tile_in and clears done on that same edge, so the initiator sees done=0 on the next cycle.
//  start while busy (any other state): ignored, no queuing.
//  States and cycle counts (one row per cycle via row counter r):
//   ST_IDLE -> ST_P1 (6: T=Gi*g row r, W=B^T*d row r, concurrent) -> ST_P2 (6: U=T*Gi^T, V=W*B)
//   -> ST_MUL (6: M row r = U.*V) -> ST_O1 (4: S=A^T*M) -> ST_O2 (4: result row r = S*A) -> ST_DONE.
//  Latency: done rises on the 27th rising edge after the accepting edge; result_out is valid on that same cycle.
//  done and result_out hold until the next accept. result_out is not cleared on accept; it updates row by row in ST_O2.
//  ST_DONE self-loops until start; there is no return to ST_IDLE.
//  Constants: Gi=24*G = [6 0 0; -4 -4 -4; -4 4 -4; 1 2 4; 1 -2 4; 0 0 24];
//   B^T = [4 0 -5 0 1 0; 0 -4 -4 1 1 0; 0 4 -4 -1 1 0; 0 -2 -1 2 1 0; 0 2 -1 -2 1 0; 0 4 0 -5 0 1];
//   A^T = [1 1 1 1 1 0; 0 1 -1 2 -2 0; 0 1 1 4 4 0; 0 1 -1 8 -8 1].
//  Arithmetic: the constant transforms use shifts/adds in DATA_W and wrap modulo 2^32.
//   ST_MUL forms the full 64-bit signed product and keeps the low 32 bits.
//   Operation is correlation: Y[r][c] = sum g[u][v]*d[r+u][c+v].
// CONFIGURATION
//  `WINOGRAD_TILE_OVF_EN defined: adds port ovf. ovf clears on accept and sets when any ST_MUL product's upper 33 bits are not all equal. It holds until the next accept or reset.
//  Undefined: no ovf port and no detection logic; the datapath is otherwise identical.
// STRUCTURE
//  winograd_pkg: state_t enum, LAT=27, Gi/B^T/A^T constant arrays, DATA_W default.
//  Sub-module winograd_const_matmul_row: combinational "row vector x constant matrix" unit.
//   Parameterised on in/out length and constant; instantiated for each pass.
//  Top holds the FSM, row counter, capture registers, scratch arrays T/W/U/V/M/S and the result register.
// TESTING
//  g[1][1]=1 (others 0), d[i][j]=6i+j -> result_out[r][c]=576*(6(r+1)+c+1); e.g. [0][0]=4032.
//  g all 1, d all 1 -> every result_out element = 5184; done exactly 27 cycles after the accepting edge.
//  g[0][0]=-1 (others 0), d all 2 -> every element = -1152 (0xFFFFFB80).
//  start pulsed at cycle 5 of a tile -> ignored, latency unchanged; done then stays 1 for 10 idle cycles and drops one cycle after the next start.
//  rst_n low at cycle 12 of a tile -> done=0, result_out=0; a fresh start then completes correctly in 27 cycles.
//  OVF_EN: g all 0x7FFFFFFF, d all 0x7FFFFFFF -> ovf=1 at done; the next tile with all-1 inputs -> ovf=0.

Source files
------------

// File: rtl/winograd_pkg.sv
// -----------------------------------------------------------------------------
// winograd_pkg
// Shared types and constants for the F(4x4,3x3) Winograd tile engine.
//   state_t      : tile engine FSM states
//   kmat_e       : selects which constant transform a row unit applies
//   GI           : 24*G (6x3), integer-scaled kernel transform
//   BT           : B^T (6x6), input transform
//   AT           : A^T (4x6), output transform
//   LAT          : edges from the accepting edge to done rising
//   WG_DATA_W    : default element width
//   kcoef()      : coefficient lookup used at elaboration by the row units
// -----------------------------------------------------------------------------
package winograd_pkg;

    localparam int WG_DATA_W = 32;
    localparam int LAT       = 27;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_MUL,
        ST_O1,
        ST_O2,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_GI,
        K_BT,
        K_AT
    } kmat_e;

    localparam int GI [6][3] = '{
        '{ 6,  0,  0},
        '{-4, -4, -4},
        '{-4,  4, -4},
        '{ 1,  2,  4},
        '{ 1, -2,  4},
        '{ 0,  0, 24}
    };

    localparam int BT [6][6] = '{
        '{4,  0, -5,  0, 1, 0},
        '{0, -4, -4,  1, 1, 0},
        '{0,  4, -4, -1, 1, 0},
        '{0, -2, -1,  2, 1, 0},
        '{0,  2, -1, -2, 1, 0},
        '{0,  4,  0, -5, 0, 1}
    };

    localparam int AT [4][6] = '{
        '{1, 1,  1, 1,  1, 0},
        '{0, 1, -1, 2, -2, 0},
        '{0, 1,  1, 4,  4, 0},
        '{0, 1, -1, 8, -8, 1}
    };

    // Element [row][col] of the selected matrix; 0 outside its bounds.
    function automatic int kcoef(kmat_e k, int row, int col);
        int v;
        v = 0;
        case (k)
            K_GI:    if (row < 6 && col < 3) v = GI[row][col];
            K_BT:    if (row < 6 && col < 6) v = BT[row][col];
            default: if (row < 4 && col < 6) v = AT[row][col];
        endcase
        return v;
    endfunction

endpackage

// File: rtl/winograd_const_matmul_row.sv
// -----------------------------------------------------------------------------
// winograd_const_matmul_row
// Combinational constant transform: out_vec[j] = sum_i K[j][i] * in_vec[i],
// with K one of the package matrices chosen by KSEL. Applied to a data row this
// is "row x K^T"; applied to a data column it is "K x column", so one unit type
// covers both the left and right multiplies of every pass.
// Coefficients are elaboration constants, so each product reduces to
// shifts/adds. All arithmetic wraps modulo 2^DATA_W.
// Ports:
//   in_vec  [IN_N]  input vector
//   out_vec [OUT_N] transformed vector
// -----------------------------------------------------------------------------
module winograd_const_matmul_row
    import winograd_pkg::*;
#(
    parameter int    DATA_W = WG_DATA_W,
    parameter int    IN_N   = 6,
    parameter int    OUT_N  = 6,
    parameter kmat_e KSEL   = K_GI
) (
    input  logic [IN_N-1:0][DATA_W-1:0]  in_vec,
    output logic [OUT_N-1:0][DATA_W-1:0] out_vec
);

    for (genvar j = 0; j < OUT_N; j++) begin : g_out
        logic [DATA_W-1:0] acc;
        always_comb begin
            acc = '0;
            for (int i = 0; i < IN_N; i++) begin
                acc = acc + in_vec[i] * DATA_W'(kcoef(KSEL, j, i));
            end
        end
        assign out_vec[j] = acc;
    end

endmodule

// File: rtl/winograd_tile_engine.sv
// -----------------------------------------------------------------------------
// winograd_tile_engine
// Responder for the tile start/done handshake. Computes one F(4x4,3x3)
// Winograd tile Y = A^T[(Gi g Gi^T) .* (B^T d B)]A with Gi = 24*G, so each
// output is 576x the true correlation. Row-serial: one row per cycle.
//   P1 (6)  T = Gi*g, W = B^T*d      P2 (6)  U = T*Gi^T, V = W*B
//   MUL(6)  M = U .* V               O1 (4)  S = A^T*M
//   O2 (4)  result row = S*A
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        request, accepted only in ST_IDLE / ST_DONE
//   kernel_in    3x3 kernel g, captured on accept
//   tile_in      6x6 input tile d, captured on accept
//   result_out   4x4 576*Y, registered, updated row by row in O2
//   done         high from completion until the next accept
//   ovf          sticky product overflow (only with WINOGRAD_TILE_OVF_EN)
// Build option: define WINOGRAD_TILE_OVF_EN to add the ovf port and detector.
// -----------------------------------------------------------------------------
module winograd_tile_engine
    import winograd_pkg::*;
#(
    parameter int DATA_W = WG_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [2:0][2:0][DATA_W-1:0]   kernel_in,
    input  logic [5:0][5:0][DATA_W-1:0]   tile_in,
    output logic [3:0][3:0][DATA_W-1:0]   result_out,
    output logic                          done
`ifdef WINOGRAD_TILE_OVF_EN
    ,
    output logic                          ovf
`endif
);

    state_t     state_q, state_d;
    logic [2:0] r_q, r_d;
    logic       accept;

    logic [2:0][2:0][DATA_W-1:0] g_q;
    logic [5:0][5:0][DATA_W-1:0] d_q;
    logic [5:0][2:0][DATA_W-1:0] t_q;
    logic [5:0][5:0][DATA_W-1:0] w_q, u_q, v_q, m_q;
    logic [3:0][5:0][DATA_W-1:0] s_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_P1;
                    r_d     = '0;
                end
            end
            ST_P1:  if (r_q == 3'd5) begin state_d = ST_P2;   r_d = '0; end else r_d = r_q + 3'd1;
            ST_P2:  if (r_q == 3'd5) begin state_d = ST_MUL;  r_d = '0; end else r_d = r_q + 3'd1;
            ST_MUL: if (r_q == 3'd5) begin state_d = ST_O1;   r_d = '0; end else r_d = r_q + 3'd1;
            ST_O1:  if (r_q == 3'd3) begin state_d = ST_O2;   r_d = '0; end else r_d = r_q + 3'd1;
            ST_O2:  if (r_q == 3'd3) begin state_d = ST_DONE; r_d = '0; end else r_d = r_q + 3'd1;
            default: begin
                state_d = ST_IDLE;
                r_d     = '0;
            end
        endcase
    end

    // ---------------- Column views for left multiplies ----------------
    logic [2:0][2:0][DATA_W-1:0] g_col;
    logic [5:0][5:0][DATA_W-1:0] d_col, m_col;

    always_comb begin
        g_col = '0;
        d_col = '0;
        m_col = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                g_col[j][i] = g_q[i][j];
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                d_col[j][i] = d_q[i][j];
                m_col[j][i] = m_q[i][j];
            end
    end

    // ---------------- Transform units ----------------
    // Left multiplies produce whole columns; only row r_q is stored per cycle.
    logic [2:0][5:0][DATA_W-1:0] t_col;
    logic [5:0][5:0][DATA_W-1:0] w_col;
    logic [5:0][3:0][DATA_W-1:0] s_col;
    logic [5:0][DATA_W-1:0]      u_row, v_row;
    logic [3:0][DATA_W-1:0]      y_row;

    for (genvar j = 0; j < 3; j++) begin : g_t
        winograd_const_matmul_row #(.DATA_W(DATA_W), .IN_N(3), .OUT_N(6), .KSEL(K_GI)) u_t (
            .in_vec (g_col[j]),
            .out_vec(t_col[j])
        );
    end

    for (genvar j = 0; j < 6; j++) begin : g_w
        winograd_const_matmul_row #(.DATA_W(DATA_W), .IN_N(6), .OUT_N(6), .KSEL(K_BT)) u_w (
            .in_vec (d_col[j]),
            .out_vec(w_col[j])
        );
    end

    winograd_const_matmul_row #(.DATA_W(DATA_W), .IN_N(3), .OUT_N(6), .KSEL(K_GI)) u_u (
        .in_vec (t_q[r_q]),
        .out_vec(u_row)
    );

    winograd_const_matmul_row #(.DATA_W(DATA_W), .IN_N(6), .OUT_N(6), .KSEL(K_BT)) u_v (
        .in_vec (w_q[r_q]),
        .out_vec(v_row)
    );

    for (genvar j = 0; j < 6; j++) begin : g_s
        winograd_const_matmul_row #(.DATA_W(DATA_W), .IN_N(6), .OUT_N(4), .KSEL(K_AT)) u_s (
            .in_vec (m_col[j]),
            .out_vec(s_col[j])
        );
    end

    winograd_const_matmul_row #(.DATA_W(DATA_W), .IN_N(6), .OUT_N(4), .KSEL(K_AT)) u_y (
        .in_vec (s_q[r_q[1:0]]),
        .out_vec(y_row)
    );

    // ---------------- Element-wise multiply ----------------
    // Only the low DATA_W bits are kept; the full product is formed only when
    // the overflow detector needs the upper half.
    logic [5:0][DATA_W-1:0] m_row;
`ifdef WINOGRAD_TILE_OVF_EN
    logic [5:0] prod_ovf;
    always_comb begin
        logic signed [2*DATA_W-1:0] prod;
        m_row    = '0;
        prod_ovf = '0;
        prod     = '0;
        for (int c = 0; c < 6; c++) begin
            prod        = $signed(u_q[r_q][c]) * $signed(v_q[r_q][c]);
            m_row[c]    = prod[DATA_W-1:0];
            // Fits in DATA_W iff the top DATA_W+1 bits are a pure sign extension.
            prod_ovf[c] = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (accept)
            ovf <= 1'b0;
        else if (state_q == ST_MUL && |prod_ovf)
            ovf <= 1'b1;
    end
`else
    always_comb begin
        m_row = '0;
        for (int c = 0; c < 6; c++)
            m_row[c] = u_q[r_q][c] * v_q[r_q][c];
    end
`endif

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q        <= '0;
            d_q        <= '0;
            t_q        <= '0;
            w_q        <= '0;
            u_q        <= '0;
            v_q        <= '0;
            m_q        <= '0;
            s_q        <= '0;
            result_out <= '0;
        end else begin
            if (accept) begin
                g_q <= kernel_in;
                d_q <= tile_in;
            end
            case (state_q)
                ST_P1: begin
                    for (int j = 0; j < 3; j++) t_q[r_q][j] <= t_col[j][r_q];
                    for (int j = 0; j < 6; j++) w_q[r_q][j] <= w_col[j][r_q];
                end
                ST_P2: begin
                    u_q[r_q] <= u_row;
                    v_q[r_q] <= v_row;
                end
                ST_MUL: m_q[r_q] <= m_row;
                ST_O1: begin
                    for (int j = 0; j < 6; j++) s_q[r_q[1:0]][j] <= s_col[j][r_q[1:0]];
                end
                ST_O2:   result_out[r_q[1:0]] <= y_row;
                default: ;
            endcase
        end
    end

    // done is registered off ST_DONE, so it rises one edge after the last
    // result row lands; accept wins so the initiator sees it drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            done <= 1'b0;
        else if (accept)
            done <= 1'b0;
        else if (state_q == ST_DONE)
            done <= 1'b1;
    end

endmodule
